// File: rtl/ibpl_pkg.sv
// Shared constants for the interbackplane input path, so the cardlets and the
// conditioning block agree on counter widths and default LED timing.
package ibpl_pkg;

  localparam int ACT_CNT_W  = 16;
  localparam int FILT_CNT_W = 8;

  // 125 MHz system clock, 100 us activity tick, 100 ms LED stretch
  localparam int CLK_FREQ_HZ = 125_000_000;
  localparam int TICK_US     = 100;
  localparam int STRETCH_MS  = 100;

  localparam int DEF_PRESC     = (CLK_FREQ_HZ / 1_000_000) * TICK_US;
  localparam int DEF_ACT_TICKS = (STRETCH_MS * 1000) / TICK_US;
  localparam int DEF_FILT_LEN  = 4;

endpackage

// File: rtl/ibpl_chan_cond.sv
// One input channel: 2-FF synchroniser, glitch filter, registered edge pulses
// and the retriggerable activity stretch counter that drives the cardlet LED.
module ibpl_chan_cond
  import ibpl_pkg::*;
#(
  parameter int FILT_LEN  = DEF_FILT_LEN,
  parameter int ACT_TICKS = DEF_ACT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic enable,
  input  logic tick,
  output logic in_filt,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic input_act
);

  localparam logic [FILT_CNT_W-1:0] FILT_LAST = FILT_CNT_W'(FILT_LEN - 1);
  localparam logic [ACT_CNT_W-1:0]  ACT_LOAD  = ACT_CNT_W'(ACT_TICKS);

  logic                  sync1;
  logic                  s;
  logic                  q;
  logic                  q_d;
  logic [FILT_CNT_W-1:0] cnt;
  logic [ACT_CNT_W-1:0]  act_cnt;
  logic                  q_changed;

  assign q_changed = q ^ q_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw_in;
      s     <= sync1;
    end
  end

  // Any return to the accepted level restarts the count, so short glitches vanish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (s == q) begin
      cnt <= '0;
    end else if (cnt == FILT_LAST) begin
      q   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + FILT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_d        <= 1'b0;
      in_filt    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      q_d        <= q;
      in_filt    <= q & enable;
      rise_pulse <= q & ~q_d & enable;
      fall_pulse <= ~q & q_d & enable;
    end
  end

  // A reload on an edge takes priority over a coincident tick decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_cnt <= '0;
    end else if (!enable) begin
      act_cnt <= '0;
    end else if (q_changed) begin
      act_cnt <= ACT_LOAD;
    end else if (tick && (act_cnt != '0)) begin
      act_cnt <= act_cnt - ACT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_act <= 1'b0;
    end else begin
      input_act <= (act_cnt != '0);
    end
  end

endmodule

// File: rtl/ibpl_input_cond.sv
// Input conditioning for all interbackplane channels: one shared activity
// prescaler plus an independent conditioning slice per channel.
module ibpl_input_cond
  import ibpl_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int FILT_LEN  = DEF_FILT_LEN,
  parameter int PRESC     = DEF_PRESC,
  parameter int ACT_TICKS = DEF_ACT_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] internal_in,
  input  logic [N_CH-1:0] input_enable,
  output logic [N_CH-1:0] in_filt,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] input_act
);

  localparam int PRESC_W = $clog2(PRESC);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  assign tick = (presc_cnt == PRESC_W'(PRESC - 1));

  // Free-running; channel events never disturb the tick phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    ibpl_chan_cond #(
      .FILT_LEN  (FILT_LEN),
      .ACT_TICKS (ACT_TICKS)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (internal_in[i]),
      .enable     (input_enable[i]),
      .tick       (tick),
      .in_filt    (in_filt[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .input_act  (input_act[i])
    );
  end

endmodule

// File: doc/ibpl_input_cond.md
Name: ibpl_input_cond

Overview:
- Per-channel input conditioning stage directly downstream of the interbackplane input cardlets.
- Consumes the cardlet's raw internal_in vector (asynchronous to clk) and does three things:
  - synchronises and glitch-filters it;
  - emits one-cycle edge pulses;
  - produces the stretched input_act vector that the cardlets display on their activity LEDs.
- Channels are gated by input_enable from the blackbox configuration.

Parameters:
- N_CH, 8, number of channels (matches cardlet internal_in width).
- FILT_LEN, 4, consecutive stable cycles required before a synchronised level change is accepted; legal range 1..255.
- PRESC, 12500, clk cycles per activity tick (100 us at 125 MHz); legal range >= 2.
- ACT_TICKS, 1000, activity stretch length in ticks (100 ms default); legal range 1..65535.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- internal_in  in  N_CH  raw channel levels from cardlet, asynchronous.
- input_enable  in  N_CH  per-channel enable, synchronous to clk.
- in_filt  out  N_CH  filtered level, forced 0 when channel disabled.
- rise_pulse  out  N_CH  one-cycle pulse on accepted 0->1 transition.
- fall_pulse  out  N_CH  one-cycle pulse on accepted 1->0 transition.
- input_act  out  N_CH  activity indicator, high while stretch counter is nonzero.

Behaviour:
- Reset (async, active-high):
  - All sync FFs, filter state q, filter counters, prescaler, activity counters and all outputs go to 0.
  - Asserting rst mid-filter or mid-stretch aborts immediately; no pulse is emitted on release.
- Sync: 2-FF synchroniser per channel. s = second stage.
- Filter, per channel:
  - State: q (accepted level) and cnt (8 bit).
  - If s == q: cnt <= 0.
  - Else if cnt == FILT_LEN-1: q <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A change is therefore accepted after FILT_LEN consecutive differing cycles. Any return to q before then resets cnt, so glitches shorter than FILT_LEN cycles are fully suppressed.
  - Latency from internal_in edge to in_filt change is 2 + FILT_LEN cycles (±1 for async sampling).
- Edges:
  - rise_pulse[i] is registered, high for exactly the cycle after q[i] goes 0->1, and only if input_enable[i] = 1 in that cycle. fall_pulse[i] is the same for 1->0.
  - A change of input_enable alone never produces a pulse.
- in_filt[i] = q[i] & input_enable[i], registered; same timing as the edge pulses.
- Prescaler:
  - Free-running 0..PRESC-1; tick is high for one cycle when the count equals PRESC-1, then the count wraps to 0.
  - Shared by all channels; not reset by channel events.
- Activity, per channel, 16-bit act_cnt. Priority, highest first:
  1. input_enable[i] = 0: act_cnt <= 0.
  2. rise or fall accepted this cycle: act_cnt <= ACT_TICKS (retrigger, extends stretch).
  3. tick and act_cnt != 0: act_cnt <= act_cnt-1.
  - Simultaneous edge and tick: reload wins; no decrement that cycle.
  - act_cnt never wraps below 0.
- input_act[i] = (act_cnt[i] != 0), registered.
  - Stretch duration after the last edge is between ACT_TICKS-1 and ACT_TICKS ticks, depending on prescaler phase.
- Channels are fully independent; no cross-channel interaction except the shared tick.

Decomposition:
- Shared package ibpl_pkg:
  - ACT_CNT_W = 16 and FILT_CNT_W = 8 constants.
  - Default timing constants (clock frequency, 100 us tick, 100 ms stretch) so cardlets and this block agree.
- Sub-module ibpl_chan_cond: one channel (sync, filter, edge, activity counter), instantiated N_CH times via generate.
- Top level holds only the prescaler and the per-channel instances.

Test Plan (PRESC=10, ACT_TICKS=3, FILT_LEN=4, all channels enabled unless stated):
- Hold internal_in[0] high for 3 cycles, then low -> in_filt, rise_pulse and input_act stay 0 throughout.
- Step internal_in[2] 0->1 and hold -> in_filt[2] = 1 and one rise_pulse[2] cycle at 6±1 cycles after the step; input_act[2] high 20..30 cycles, then 0.
- Toggle internal_in[1] every 15 cycles for 100 cycles -> alternating rise/fall pulses each accepted edge; input_act[1] stays continuously high (retrigger), then drops within 30 cycles after the last edge.
- Hold input_enable[3] = 0 and step internal_in[3] -> no pulses, in_filt[3] = 0, input_act[3] = 0. Then raise enable with input high -> in_filt[3] = 1 the next cycle, no rise_pulse.
- Assert rst for 1 cycle while input_act[4] is active and a filter count is in progress -> all outputs 0 immediately; after release, a stable high input yields exactly one rise_pulse.
- Arrange an edge acceptance in the same cycle as a tick -> act_cnt = 3 the following cycle (reload wins over decrement).
